gray_to_binary_pipe: RTL and testbench
======================================

Name: gray_to_binary_pipe

Overview:
- Pipelined Gray-to-binary decoder with a valid/ready handshake on both sides. It is the receive-side counterpart of binary_to_gray.
- Intended for Gray-coded counters and pointers that arrive from another block or clock domain.
- Also checks that consecutive accepted Gray words differ by at most one bit, and counts violations.

Parameters:
- WIDTH, 4, bit width of the Gray input and binary output; legal range 2..32.
- STAGES, 2, number of register stages in the decode path; legal range 1..WIDTH; equals the latency in cycles.

Ports:
- i_clk  input  1  clock; all registers update on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream: i_gray holds a valid word.
- o_ready  output  1  upstream: this block accepts a word this cycle.
- i_gray  input  WIDTH  Gray-coded word.
- o_valid  output  1  downstream: o_binary holds a valid word.
- i_ready  input  1  downstream: the consumer accepts the word this cycle.
- o_binary  output  WIDTH  decoded binary word.
- o_step_err  output  1  qualified by o_valid; the word's Gray input differed from the previous accepted word in 2 or more bits.
- o_err_count  output  8  saturating count of delivered words with o_step_err set.

Behaviour:
- Reset (i_rst_n low, asynchronous assert):
  - All stage valid bits clear.
  - o_valid=0, o_binary=0, o_step_err=0, o_err_count=0.
  - The previous-word register is cleared and marked empty.
  - o_ready=1 from the first cycle after reset.
  - Deassertion is sampled synchronously.
- Accept and deliver:
  - An input word is accepted when i_valid && o_ready at a rising edge.
  - An output word is delivered when o_valid && i_ready.
- Decode rule:
  - binary[WIDTH-1] = gray[WIDTH-1].
  - binary[k] = binary[k+1] XOR gray[k].
  - The prefix-XOR chain is split across STAGES register stages in roughly equal bit groups, MSB group first. Each stage carries the partial binary result, the remaining Gray bits and the error flag.
- Latency and throughput:
  - An accepted word appears on o_binary exactly STAGES cycles later when there is no back-pressure.
  - Throughput is one word per cycle when i_ready is held high.
- Stage advance:
  - Stage s loads when it is empty or its contents move forward this cycle.
  - The last stage moves forward when i_ready=1.
  - o_ready = (first stage empty) || (first stage advancing).
  - Bubbles collapse: an empty stage never blocks an upstream stage.
- Back-pressure:
  - While o_valid && !i_ready, o_binary and o_step_err hold stable.
  - No word is dropped or duplicated.
  - o_ready falls only once every stage is full.
- Step check, evaluated at accept time against the last accepted Gray word:
  - Popcount of (i_gray XOR prev) of 0 or 1: error flag = 0.
  - Popcount of 2 or more: error flag = 1.
  - The first word after reset is never flagged.
  - prev updates on every accept.
  - The flag travels through the pipeline aligned with its word.
- Error counter:
  - Increments on delivery of a word with o_step_err=1.
  - Saturates at 255 and does not wrap.
- Simultaneous accept and deliver in the same cycle with the pipeline full: the pipeline shifts and the new word enters. Occupancy is unchanged.
- Reset mid-stream: in-flight words are discarded, the outputs clear immediately, and the step check restarts with an empty prev.
- Inputs are ignored while o_ready=0. i_gray may change freely when i_valid=0.

Test Plan:
- Reset:
  - Stimulus: assert i_rst_n=0 mid-cycle with i_valid=1.
  - Required: o_valid, o_binary, o_step_err and o_err_count go to 0 immediately; o_ready=1 the cycle after release.
- Full sweep (WIDTH=4, STAGES=2, i_ready=1):
  - Stimulus: stream the 16 Gray codes 0000,0001,0011,0010,0110,...,1000 back-to-back.
  - Required: o_binary reads 0..15, each exactly 2 cycles after its accept; o_step_err=0 throughout; o_err_count=0.
- Spot values:
  - Gray 0111 -> 0101.
  - Gray 1110 -> 1011.
  - Gray 1000 -> 1111.
  - Gray 0000 -> 0000.
  - Each appears with o_valid=1 at latency 2.
- Back-pressure:
  - Stimulus: during a continuous stream, hold i_ready=0 for 4 cycles.
  - Required: o_binary stays frozen; o_ready=0 after the 2 stages fill; on release the sequence resumes in order with no gaps or repeats.
- Step error:
  - Stimulus: accept 0000, then 0111, then 0111, then 0101.
  - Required: flags 0,1,0,0; o_err_count=1 after delivery of the second word.
  - Follow-up: 300 alternating 0000/1111 words drive o_err_count to saturate at 255.
- Reset mid-stream:
  - Stimulus: assert reset with 2 words in flight; after release, accept 1111.
  - Required: the in-flight words are never delivered; 1111 decodes to 1010 with o_step_err=0.

Source files
------------

// File: rtl/gray_to_binary_pipe.sv
// Pipelined Gray-to-binary decoder with valid/ready handshakes on both sides.
// The prefix-XOR chain is split across STAGES register stages (MSB group
// first). At accept time each word is compared against the previously
// accepted Gray word; a jump of 2 or more bits raises a step-error flag that
// rides along with the word, and delivered flagged words are counted in a
// saturating 8-bit counter.
module gray_to_binary_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_gray,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_binary,
    output logic             o_step_err,
    output logic [7:0]       o_err_count
);

    // Resolve the bits of group s: every bit below the MSB becomes the XOR of
    // its already-decoded upper neighbour and its own Gray bit. Bits above the
    // group are already binary, bits below are still Gray.
    function automatic logic [WIDTH-1:0] decode_group(input logic [WIDTH-1:0] w, input int s);
        logic [WIDTH-1:0] r;
        int lo;
        int hi;
        r  = w;
        lo = WIDTH - ((s + 1) * WIDTH) / STAGES;
        hi = WIDTH - 1 - (s * WIDTH) / STAGES;
        for (int k = WIDTH - 2; k >= 0; k--) begin
            if (k >= lo && k <= hi) begin
                r[k] = r[k + 1] ^ r[k];
            end
        end
        return r;
    endfunction

    // True when x has two or more bits set (clearing the lowest set bit
    // leaves something behind).
    function automatic logic multi_bit(input logic [WIDTH-1:0] x);
        return (x & (x - WIDTH'(1))) != '0;
    endfunction

    // Saturating increment: sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] err_p;
    logic [WIDTH-1:0]  word_p [STAGES];

    logic [STAGES-1:0] load;
    logic [STAGES-1:0] move;
    logic [STAGES-1:0] vld_in;
    logic [STAGES-1:0] err_in;
    logic [WIDTH-1:0]  word_in [STAGES];

    logic [WIDTH-1:0]  prev_gray;
    logic              prev_full;
    logic              accept;
    logic              step_err;
    logic [7:0]        err_count;

    assign accept   = i_valid && o_ready;
    assign step_err = prev_full && multi_bit(i_gray ^ prev_gray);

    // Stage inputs: stage 0 takes the live Gray word, later stages take the
    // previous stage register and decode their own bit group.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage_in
        if (s == 0) begin : g_first
            assign vld_in[s]  = i_valid;
            assign err_in[s]  = step_err;
            assign word_in[s] = decode_group(i_gray, s);
        end else begin : g_rest
            assign vld_in[s]  = vld_p[s-1];
            assign err_in[s]  = err_p[s-1];
            assign word_in[s] = decode_group(word_p[s-1], s);
        end
    end

    // Advance chain, walked from the output back: a stage moves when it holds
    // a word and its successor loads; it loads when empty or moving, so
    // bubbles never block upstream stages.
    always_comb begin
        logic down_ok;
        load    = '0;
        move    = '0;
        down_ok = i_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            move[s] = vld_p[s] && down_ok;
            load[s] = !vld_p[s] || move[s];
            down_ok = load[s];
        end
    end

    // Pipeline registers: each stage captures its input whenever it loads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p <= '0;
            err_p <= '0;
            for (int s = 0; s < STAGES; s++) begin
                word_p[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (load[s]) begin
                    vld_p[s] <= vld_in[s];
                    if (vld_in[s]) begin
                        word_p[s] <= word_in[s];
                        err_p[s]  <= err_in[s];
                    end
                end
            end
        end
    end

    // Last accepted Gray word, the reference for the step check.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_gray <= '0;
            prev_full <= 1'b0;
        end else if (accept) begin
            prev_gray <= i_gray;
            prev_full <= 1'b1;
        end
    end

    // Count delivered words that carry the step-error flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_count <= '0;
        end else if (o_valid && i_ready && o_step_err) begin
            err_count <= sat_inc(err_count);
        end
    end

    assign o_ready     = load[0];
    assign o_valid     = vld_p[STAGES-1];
    assign o_binary    = word_p[STAGES-1];
    assign o_step_err  = err_p[STAGES-1];
    assign o_err_count = err_count;

endmodule

// File: tb/tb_gray_to_binary_pipe.sv
// Directed bench for gray_to_binary_pipe (WIDTH=4, STAGES=2): table-driven
// streams plus hand-written back-pressure, saturation and reset sequences.
module tb_gray_to_binary_pipe;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_gray;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_binary;
    logic       o_step_err;
    logic [7:0] o_err_count;

    int checks;
    int errors;

    gray_to_binary_pipe #(.WIDTH(4), .STAGES(2)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_gray      (i_gray),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_binary    (o_binary),
        .o_step_err  (o_step_err),
        .o_err_count (o_err_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
        logic       err;
    } vec_t;

    vec_t tab [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_gray  = 4'h0;
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    // Stream tab[first .. first+n-1] back-to-back with i_ready=1; each word
    // must appear exactly 2 cycles after its accept. cnt0 is the expected
    // error count at the start.
    task automatic run_seq(input int first, input int n, input int cnt0);
        int exp_cnt;
        exp_cnt = cnt0;
        for (int i = 0; i <= n; i++) begin
            i_ready = 1'b1;
            i_valid = (i < n);
            if (i < n) i_gray = tab[first + i].gray;
            #1;
            if (i < n) chk("seq_ready", o_ready, 1);
            tick();
            if (i == 0) begin
                chk("seq_lat_early", o_valid, 0);
            end else begin
                chk("seq_valid", o_valid, 1);
                chk("seq_bin", o_binary, tab[first + i - 1].bin);
                chk("seq_flag", o_step_err, tab[first + i - 1].err);
                chk("seq_cnt", o_err_count, exp_cnt);
                if (tab[first + i - 1].err && exp_cnt < 255) exp_cnt++;
            end
        end
        i_valid = 1'b0;
        tick();
        chk("seq_drained", o_valid, 0);
        chk("seq_cnt_end", o_err_count, exp_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int got;
        logic acc;
        checks = 0;
        errors = 0;

        // Full Gray sweep: binary value equals index.
        tab[0]  = '{4'b0000, 4'd0,  1'b0};
        tab[1]  = '{4'b0001, 4'd1,  1'b0};
        tab[2]  = '{4'b0011, 4'd2,  1'b0};
        tab[3]  = '{4'b0010, 4'd3,  1'b0};
        tab[4]  = '{4'b0110, 4'd4,  1'b0};
        tab[5]  = '{4'b0111, 4'd5,  1'b0};
        tab[6]  = '{4'b0101, 4'd6,  1'b0};
        tab[7]  = '{4'b0100, 4'd7,  1'b0};
        tab[8]  = '{4'b1100, 4'd8,  1'b0};
        tab[9]  = '{4'b1101, 4'd9,  1'b0};
        tab[10] = '{4'b1111, 4'd10, 1'b0};
        tab[11] = '{4'b1110, 4'd11, 1'b0};
        tab[12] = '{4'b1010, 4'd12, 1'b0};
        tab[13] = '{4'b1011, 4'd13, 1'b0};
        tab[14] = '{4'b1001, 4'd14, 1'b0};
        tab[15] = '{4'b1000, 4'd15, 1'b0};
        // Spot values after a reset; jumps 0111->1110 and 1110->1000 are 2 bits.
        tab[16] = '{4'b0111, 4'b0101, 1'b0};
        tab[17] = '{4'b1110, 4'b1011, 1'b1};
        tab[18] = '{4'b1000, 4'b1111, 1'b1};
        tab[19] = '{4'b0000, 4'b0000, 1'b0};
        // Step-error sequence.
        tab[20] = '{4'b0000, 4'b0000, 1'b0};
        tab[21] = '{4'b0111, 4'b0101, 1'b1};
        tab[22] = '{4'b0111, 4'b0101, 1'b0};
        tab[23] = '{4'b0101, 4'b0110, 1'b0};

        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_gray  = 4'hF;
        #3;
        chk("rst_valid", o_valid, 0);
        chk("rst_bin", o_binary, 0);
        chk("rst_flag", o_step_err, 0);
        chk("rst_cnt", o_err_count, 0);
        do_reset();
        chk("rst_ready", o_ready, 1);

        run_seq(0, 16, 0);

        do_reset();
        run_seq(16, 4, 0);

        do_reset();
        run_seq(20, 4, 0);

        // 300 alternating 0000/1111 words: every one is a multi-bit jump.
        for (int i = 0; i < 300; i++) begin
            i_ready = 1'b1;
            i_valid = 1'b1;
            i_gray  = (i % 2 == 0) ? 4'b0000 : 4'b1111;
            tick();
        end
        i_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("sat_cnt", o_err_count, 255);

        // Back-pressure: stream 12 words, hold i_ready low for 4 cycles.
        do_reset();
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
            i_ready = !(cyc >= 5 && cyc < 9);
            i_valid = (sent < 12);
            i_gray  = tab[(sent < 12) ? sent : 0].gray;
            #1;
            if (!i_ready) begin
                chk("bp_hold_valid", o_valid, 1);
                chk("bp_hold_bin", o_binary, tab[got].bin);
                chk("bp_ready_low", o_ready, 0);
            end else if (o_valid) begin
                chk("bp_order", o_binary, tab[got].bin);
                got++;
            end
            acc = i_valid && o_ready;
            tick();
            if (acc) sent++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("bp_delivered", got, 12);
        tick();
        chk("bp_no_extra", o_valid, 0);

        // Reset mid-stream with two words in flight.
        i_valid = 1'b1;
        i_gray  = 4'b0001;
        tick();
        i_gray  = 4'b0011;
        tick();
        i_gray  = 4'b0010;
        chk("mid_pre_valid", o_valid, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_bin", o_binary, 0);
        chk("mid_rst_flag", o_step_err, 0);
        chk("mid_rst_cnt", o_err_count, 0);
        tick();
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        tick();
        chk("mid_ready", o_ready, 1);
        chk("mid_no_ghost0", o_valid, 0);
        i_valid = 1'b1;
        i_gray  = 4'b1111;
        tick();
        i_valid = 1'b0;
        chk("mid_no_ghost1", o_valid, 0);
        tick();
        chk("mid_valid", o_valid, 1);
        chk("mid_bin", o_binary, 4'b1010);
        chk("mid_flag", o_step_err, 0);
        chk("mid_cnt", o_err_count, 0);
        tick();
        chk("mid_drained", o_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
